// File: rtl/jtag_seq_pkg.sv
// jtag_seq_pkg: shared opcodes, FSM states and control-word field positions
// for the JTAG register sequencer.
package jtag_seq_pkg;

    typedef enum logic [1:0] {
        OP_CTRL     = 2'b00,
        OP_SET_ADDR = 2'b01,
        OP_LOAD_LO  = 2'b10,
        OP_COMMIT   = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DECODE = 2'b01,
        ST_WRITE  = 2'b10
    } state_e;

    localparam int OPC_MSB     = 7;
    localparam int OPC_LSB     = 6;
    localparam int AUTOINC_BIT = 4;
    localparam int CLR_OVR_BIT = 0;
    localparam int VIEW_BIT    = 1;

endpackage

// File: rtl/sync_rise_edge.sv
// sync_rise_edge: multi-flop synchronizer for an asynchronous level, plus a
// one-cycle pulse on its synchronized rising edge.
module sync_rise_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
        rise   = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/jtag_reg_sequencer.sv
// jtag_reg_sequencer: decodes JTAG Update-DR control words into shadow register
// writes, forwards each commit over valid/ready and drives a readback status word.
module jtag_reg_sequencer
    import jtag_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   jtag_control,
    input  logic                         jtag_udr,
    output logic [7:0]                   jtag_status,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [7:0]                   wr_data,
    output logic [8*(2**ADDR_WIDTH)-1:0] regs
);

    localparam int NREGS = 2**ADDR_WIDTH;

    logic                  evt;
    state_e                state_q, state_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            stage_lo_q, stage_lo_d;
    logic                  view_q, view_d;
    logic                  overrun_q, overrun_d;
    logic [8*NREGS-1:0]    shadow_q, shadow_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [7:0]            status_q, status_d;
    opcode_e               op;
    logic [7:0]            data;
    logic [ADDR_WIDTH+2:0] idx;
    logic                  unused_payload;

    sync_rise_edge #(.STAGES(SYNC_STAGES)) u_udr_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (jtag_udr),
        .rise (evt)
    );

    assign op             = opcode_e'(cmd_q[OPC_MSB:OPC_LSB]);
    assign data           = {cmd_q[3:0], stage_lo_q};
    assign idx            = {addr_q, 3'b000};
    assign unused_payload = cmd_q[5];

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        stage_lo_d = stage_lo_q;
        view_d     = view_q;
        overrun_d  = overrun_q;
        shadow_d   = shadow_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            ST_IDLE: if (evt) begin
                cmd_d   = jtag_control;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                case (op)
                    OP_CTRL: begin
                        if (cmd_q[CLR_OVR_BIT]) overrun_d = 1'b0;
                        view_d = cmd_q[VIEW_BIT];
                    end
                    OP_SET_ADDR: addr_d = cmd_q[ADDR_WIDTH-1:0];
                    OP_LOAD_LO:  stage_lo_d = cmd_q[3:0];
                    OP_COMMIT: begin
                        shadow_d[idx +: 8] = data;
                        wr_addr_d          = addr_q;
                        wr_data_d          = data;
                        wr_valid_d         = 1'b1;
                        state_d            = ST_WRITE;
                    end
                endcase
            end
            ST_WRITE: if (wr_ready) begin
                wr_valid_d = 1'b0;
                state_d    = ST_IDLE;
                if (cmd_q[AUTOINC_BIT]) addr_d = addr_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // A new Update-DR while busy is dropped; flagging it wins over a same-cycle clear.
        if (evt && state_q != ST_IDLE) overrun_d = 1'b1;
        status_d = view_q ? {overrun_q, state_q != ST_IDLE, 6'(addr_q)} : shadow_q[idx +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            stage_lo_q <= '0;
            view_q     <= 1'b0;
            overrun_q  <= 1'b0;
            shadow_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            stage_lo_q <= stage_lo_d;
            view_q     <= view_d;
            overrun_q  <= overrun_d;
            shadow_q   <= shadow_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            status_q   <= status_d;
        end
    end

    assign jtag_status = status_q;
    assign wr_valid    = wr_valid_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign regs        = shadow_q;

endmodule
